remote_load_wb_queue: RTL and testbench

- Buffers long-latency remote/FP load responses returning to the core.
- Drains them into the integer register file write port in cycles when the main pipeline does not use that port.
- Each register write produces the matching clear pulse for the dependency scoreboard, one id per cycle.
- SIMD responses write four consecutive registers over four beats and clear each one.

---
 rtl/remote_load_wb_queue.sv | 135 +++++++++++++
 tb/tb_remote_load_wb_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/remote_load_wb_queue.sv
// Queue for long-latency remote/FP load responses. Entries drain into the integer
// RF write port on cycles the main pipeline leaves free, clearing the scoreboard per write.
module remote_load_wb_queue #(
  parameter int els_p             = 4,
  parameter int data_width_p      = 32,
  parameter int reg_els_p         = 32,
  parameter int starve_limit_p    = 8,
  parameter int x0_tied_to_zero_p = 0,
  localparam int id_width_lp      = $clog2(reg_els_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      resp_v_i,
  output logic                      resp_ready_o,
  input  logic [id_width_lp-1:0]    resp_id_i,
  input  logic                      resp_simd_i,
  input  logic [4*data_width_p-1:0] resp_data_i,
  input  logic                      pipe_wb_v_i,
  output logic                      rf_wen_o,
  output logic [id_width_lp-1:0]    rf_waddr_o,
  output logic [data_width_p-1:0]   rf_wdata_o,
  output logic                      clear_o,
  output logic [id_width_lp-1:0]    clear_id_o,
  output logic                      stall_pipe_o,
  output logic                      empty_o
);

  localparam int ptr_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp  = $clog2(els_p + 1);
  localparam int stv_w_lp  = $clog2(starve_limit_p + 1);
  localparam logic [stv_w_lp-1:0] starve_max_lp = stv_w_lp'(starve_limit_p);

  typedef struct packed {
    logic [id_width_lp-1:0]             id;
    logic                               simd;
    logic [3:0][data_width_p-1:0]       data;
  } entry_t;

  typedef enum logic {IDLE, BEAT} state_e;

  entry_t                mem_q [els_p];
  state_e                state_q, state_d;
  logic [cnt_w_lp-1:0]   count_q, count_d;
  logic [ptr_w_lp-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            beat_q, beat_d;
  logic [stv_w_lp-1:0]   starve_q, starve_d;
  logic                  stall_q, stall_d;

  entry_t                head;
  logic                  head_v, fire, last, pop, push, suppress;
  logic [id_width_lp-1:0] addr;

  assign head         = mem_q[rd_ptr_q];
  assign head_v       = (state_q == BEAT);
  assign fire         = head_v & ~pipe_wb_v_i;
  assign last         = ~head.simd | (beat_q == 2'd3);
  assign pop          = fire & last;
  assign resp_ready_o = (count_q != cnt_w_lp'(els_p));
  assign push         = resp_v_i & resp_ready_o;

  // Lane base + beat wraps modulo the id space; an x0 beat still advances the FSM.
  assign addr       = head.id + id_width_lp'(beat_q);
  assign suppress   = (x0_tied_to_zero_p != 0) && (addr == '0);
  assign rf_wen_o   = fire & ~suppress;
  assign clear_o    = fire & ~suppress;
  assign rf_waddr_o = head_v ? addr : '0;
  assign clear_id_o = head_v ? addr : '0;
  assign rf_wdata_o = head_v ? head.data[beat_q] : '0;

  assign stall_pipe_o = stall_q;
  assign empty_o      = (count_q == '0);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    stall_d  = stall_q;
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
    if (fire) beat_d = last ? 2'd0 : beat_q + 2'd1;
    if (fire)
      starve_d = '0;
    else if (head_v && pipe_wb_v_i && starve_q != starve_max_lp)
      starve_d = starve_q + stv_w_lp'(1);
    // Stall is held until the head entry's final beat, even across partial SIMD beats.
    if (pop)
      stall_d = 1'b0;
    else if (starve_d == starve_max_lp)
      stall_d = 1'b1;
    state_d = (count_d != '0) ? BEAT : IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q].id   <= resp_id_i;
      mem_q[wr_ptr_q].simd <= resp_simd_i;
      mem_q[wr_ptr_q].data <= resp_data_i;
    end
  end

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(stall_q && pipe_wb_v_i));
      assert (!(push && resp_simd_i && resp_id_i == '0 && x0_tied_to_zero_p != 0));
    end
  end

endmodule

// File: tb/tb_remote_load_wb_queue.sv
// Directed bench for remote_load_wb_queue: scoreboard of expected RF writes per instance,
// one instance with x0 writable and one with x0 tied to zero, sharing all inputs.
module tb_remote_load_wb_queue;

  localparam int ID_W = 5;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            resp_v;
  logic [ID_W-1:0] resp_id;
  logic            resp_simd;
  logic [4*DW-1:0] resp_data;
  logic            pipe_wb_v;

  logic            resp_ready_o, rf_wen_o, clear_o, stall_pipe_o, empty_o;
  logic [ID_W-1:0] rf_waddr_o, clear_id_o;
  logic [DW-1:0]   rf_wdata_o;
  logic            x_ready, x_wen, x_clear, x_stall, x_empty;
  logic [ID_W-1:0] x_waddr, x_clear_id;
  logic [DW-1:0]   x_wdata;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [ID_W-1:0] addr;
    logic [DW-1:0]   data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  remote_load_wb_queue #(.x0_tied_to_zero_p(0)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .resp_v_i(resp_v), .resp_ready_o(resp_ready_o),
    .resp_id_i(resp_id), .resp_simd_i(resp_simd), .resp_data_i(resp_data),
    .pipe_wb_v_i(pipe_wb_v), .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .clear_o(clear_o), .clear_id_o(clear_id_o),
    .stall_pipe_o(stall_pipe_o), .empty_o(empty_o)
  );

  remote_load_wb_queue #(.x0_tied_to_zero_p(1)) dut_x0 (
    .clk_i(clk), .reset_n_i(reset_n), .resp_v_i(resp_v), .resp_ready_o(x_ready),
    .resp_id_i(resp_id), .resp_simd_i(resp_simd), .resp_data_i(resp_data),
    .pipe_wb_v_i(pipe_wb_v), .rf_wen_o(x_wen), .rf_waddr_o(x_waddr),
    .rf_wdata_o(x_wdata), .clear_o(x_clear), .clear_id_o(x_clear_id),
    .stall_pipe_o(x_stall), .empty_o(x_empty)
  );

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(logic [ID_W-1:0] id, logic simd, logic [4*DW-1:0] data);
    exp_t e;
    for (int b = 0; b < (simd ? 4 : 1); b++) begin
      e.addr = id + ID_W'(b);
      e.data = data[b*DW +: DW];
      q0.push_back(e);
      if (e.addr != '0) q1.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [ID_W-1:0] id, logic simd, logic [4*DW-1:0] data);
    int n = 0;
    resp_v = 1'b1; resp_id = id; resp_simd = simd; resp_data = data;
    @(negedge clk);
    while (!resp_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", resp_ready_o, 1'b1);
    if (resp_ready_o) push_exp(id, simd, data);
    tick();
    resp_v = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (!(empty_o && x_empty) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_empty", empty_o, 1'b1);
    chk("drain_empty_x0", x_empty, 1'b1);
  endtask

  // Scoreboard: every observed write/clear must match the next expected beat in order.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rf_wen_o) begin
        if (q0.size() == 0) chk("unexpected_write", rf_wen_o, 1'b0);
        else begin
          e0 = q0.pop_front();
          chk("waddr", rf_waddr_o, e0.addr);
          chk("wdata", rf_wdata_o, e0.data);
          chk("clear", clear_o, 1'b1);
          chk("clear_id", clear_id_o, e0.addr);
        end
      end else chk("clear_without_write", clear_o, 1'b0);
      if (x_wen) begin
        if (q1.size() == 0) chk("x0_unexpected_write", x_wen, 1'b0);
        else begin
          e1 = q1.pop_front();
          chk("x0_waddr", x_waddr, e1.addr);
          chk("x0_wdata", x_wdata, e1.data);
          chk("x0_clear", x_clear, 1'b1);
          chk("x0_clear_id", x_clear_id, e1.addr);
        end
      end else chk("x0_clear_without_write", x_clear, 1'b0);
    end
  end

  initial begin
    reset_n = 1'b1; resp_v = 1'b0; resp_id = '0; resp_simd = 1'b0;
    resp_data = '0; pipe_wb_v = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ready", resp_ready_o, 1'b1);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_wen", rf_wen_o, 1'b0);
    chk("rst_clear", clear_o, 1'b0);
    chk("rst_waddr", rf_waddr_o, '0);
    chk("rst_wdata", rf_wdata_o, '0);
    chk("rst_stall", stall_pipe_o, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Scalar on an idle port
    send(5'd5, 1'b0, 128'hDEADBEEF);
    chk("scalar_wen_t1", rf_wen_o, 1'b1);
    chk("scalar_waddr_t1", rf_waddr_o, 5'd5);
    chk("scalar_wdata_t1", rf_wdata_o, 32'hDEADBEEF);
    chk("scalar_clear_id_t1", clear_id_o, 5'd5);
    tick();
    chk("scalar_empty_t2", empty_o, 1'b1);

    // SIMD with one blocked drain cycle
    send(5'd8, 1'b1, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("simd_beat0_addr", rf_waddr_o, 5'd8);
    tick();
    pipe_wb_v = 1'b1;
    #1;
    chk("simd_blocked_wen", rf_wen_o, 1'b0);
    chk("simd_blocked_clear", clear_o, 1'b0);
    chk("simd_blocked_addr", rf_waddr_o, 5'd9);
    tick();
    pipe_wb_v = 1'b0;
    drain(20);

    // Wrap-around SIMD, x0 beat suppressed only in the tied-zero instance
    send(5'd30, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    tick(); tick();
    chk("wrap_addr0", rf_waddr_o, 5'd0);
    chk("wrap_wen_x0_writable", rf_wen_o, 1'b1);
    chk("wrap_x0_wen_suppressed", x_wen, 1'b0);
    chk("wrap_x0_clear_suppressed", x_clear, 1'b0);
    tick();
    chk("wrap_x0_advanced", x_waddr, 5'd1);
    drain(20);

    // Full queue, then pop and a 5th response in the same cycle
    pipe_wb_v = 1'b1;
    for (int i = 1; i <= 4; i++) send(ID_W'(i), 1'b0, 128'(32'h100 + i));
    chk("full_ready", resp_ready_o, 1'b0);
    resp_v = 1'b1; resp_id = 5'd20; resp_simd = 1'b0; resp_data = 128'h555;
    pipe_wb_v = 1'b0;
    #1;
    chk("full_pop_ready", resp_ready_o, 1'b0);
    chk("full_pop_wen", rf_wen_o, 1'b1);
    tick();
    chk("after_pop_ready", resp_ready_o, 1'b1);
    send(5'd20, 1'b0, 128'h555);
    drain(30);

    // Starvation
    pipe_wb_v = 1'b1;
    send(5'd7, 1'b0, 128'h7777);
    for (int i = 0; i < 7; i++) tick();
    chk("starve_no_stall_7", stall_pipe_o, 1'b0);
    tick();
    chk("starve_stall_8", stall_pipe_o, 1'b1);
    pipe_wb_v = 1'b0;
    #1;
    chk("starve_fire", rf_wen_o, 1'b1);
    tick();
    chk("starve_stall_fall", stall_pipe_o, 1'b0);
    chk("starve_empty", empty_o, 1'b1);

    // Reset in the middle of a SIMD drain
    send(5'd12, 1'b1, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    tick();
    reset_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    chk("mid_rst_wen", rf_wen_o, 1'b0);
    chk("mid_rst_clear", clear_o, 1'b0);
    chk("mid_rst_ready", resp_ready_o, 1'b1);
    chk("mid_rst_empty", empty_o, 1'b1);
    chk("mid_rst_waddr", rf_waddr_o, '0);
    tick(); tick();
    chk("mid_rst_held_wen", rf_wen_o, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_empty", empty_o, 1'b1);

    chk("sb_drained", 32'(q0.size()), 32'd0);
    chk("sb_x0_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
